// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit (low), 2-bit port, LEN_W-bit length, N data bits, then one high guard bit.
// All fields go out MSB first, one bit per clkEn tick.
module serial_frame_tx #(
  parameter int LEN_W  = 4,
  parameter int DATA_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              start,
  input  logic [1:0]        port,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic              serOut,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    LEN,
    DATA,
    GUARD
  } state_t;

  localparam int SH_W = 2 + LEN_W + DATA_W;

  state_t            state;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  nbits;
  logic [SH_W-1:0]   shreg;
  logic [DATA_W-1:0] data_aligned;
  logic [31:0]       shamt;

  // Left-justify the payload so data[N-1] sits right behind the length field
  // and the unused upper bits fall off the top.
  assign shamt        = DATA_W - 32'(len);
  assign data_aligned = data << shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      nbits  <= '0;
      shreg  <= '0;
      serOut <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clkEn) begin
        case (state)
          IDLE: begin
            if (start && (len != '0)) begin
              shreg  <= {port, len, data_aligned};
              nbits  <= len;
              serOut <= 1'b0;
              busy   <= 1'b1;
              state  <= START;
            end
          end
          START: begin
            serOut <= shreg[SH_W-1];
            shreg  <= shreg << 1;
            cnt    <= LEN_W'(1);
            state  <= ADDR;
          end
          ADDR: begin
            // cnt counts the bits of the current field still to come after the one on the line
            serOut <= shreg[SH_W-1];
            shreg  <= shreg << 1;
            if (cnt == '0) begin
              cnt   <= LEN_W'(LEN_W - 1);
              state <= LEN;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          LEN: begin
            serOut <= shreg[SH_W-1];
            shreg  <= shreg << 1;
            if (cnt == '0) begin
              cnt   <= nbits - 1'b1;
              state <= DATA;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DATA: begin
            if (cnt == '0) begin
              serOut <= 1'b1;
              done   <= 1'b1;
              state  <= GUARD;
            end else begin
              serOut <= shreg[SH_W-1];
              shreg  <= shreg << 1;
              cnt    <= cnt - 1'b1;
            end
          end
          GUARD: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            serOut <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: driver pushes model frames into a queue, a monitor rebuilds frames
// from the line on clkEn ticks and compares them, including done pulse count and position.
module tb_serial_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clkEn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  port = '0;
  logic [3:0]  len = '0;
  logic [14:0] data = '0;
  logic        serOut;
  logic        busy;
  logic        done;

  serial_frame_tx #(.LEN_W(4), .DATA_W(15)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .start(start), .port(port),
    .len(len), .data(data), .serOut(serOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bits;
    int          n;
  } frame_t;

  frame_t exp_q[$];
  int     asserts = 0;
  int     fails = 0;
  int     en_div = 1;
  int     en_cnt = 0;
  logic   tick_seen = 1'b0;
  int     frames_seen = 0;

  // clkEn changes shortly after each rising edge, so it is stable around the next edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      en_cnt++;
      clkEn = ((en_cnt % en_div) == 0);
    end
  end

  always @(posedge clk) tick_seen = clkEn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    asserts++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Time-ordered list of line bits for one frame, guard bit included.
  function automatic frame_t model(input logic [1:0] p, input logic [3:0] n, input logic [14:0] d);
    frame_t f;
    f.bits = '0;
    f.n = 0;
    f.bits[f.n] = 1'b0; f.n++;
    for (int i = 1; i >= 0; i--) begin f.bits[f.n] = p[i]; f.n++; end
    for (int i = 3; i >= 0; i--) begin f.bits[f.n] = n[i]; f.n++; end
    for (int i = int'(n) - 1; i >= 0; i--) begin f.bits[f.n] = d[i]; f.n++; end
    f.bits[f.n] = 1'b1; f.n++;
    return f;
  endfunction

  initial begin : monitor
    logic [31:0] obs;
    int          n_obs;
    int          done_cnt;
    int          done_at;
    bit          in_frame;
    logic        prev_ser;
    logic        prev_busy;
    frame_t      f;
    obs = '0; n_obs = 0; done_cnt = 0; done_at = -1; in_frame = 0;
    prev_ser = 1'b1; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        obs = '0; n_obs = 0; done_cnt = 0; done_at = -1; in_frame = 0;
        exp_q.delete();
      end else begin
        if (tick_seen) begin
          if (busy) begin
            if (n_obs < 32) obs[n_obs] = serOut;
            n_obs++;
            in_frame = 1;
          end else if (in_frame) begin
            frames_seen++;
            if (exp_q.size() == 0) begin
              asserts++;
              fails++;
              $display("FAIL unexpected_frame: got a %0d-bit frame 0x%0h, required none", n_obs, obs);
            end else begin
              f = exp_q.pop_front();
              $display("frame %0d: %0d line bits 0x%0h (model %0d bits 0x%0h), done pulses %0d",
                       frames_seen, n_obs, obs, f.n, f.bits, done_cnt);
              chk("frame_len", n_obs, f.n);
              chk("frame_bits", obs, f.bits);
              chk("done_count", done_cnt, 1);
              chk("done_pos", done_at, f.n);
            end
            obs = '0; n_obs = 0; done_cnt = 0; done_at = -1; in_frame = 0;
          end
        end else begin
          chk("freeze_serOut", serOut, prev_ser);
          chk("freeze_busy", busy, prev_busy);
        end
        if (done && in_frame) begin
          done_cnt++;
          done_at = n_obs;
        end
        if (!busy && !in_frame) begin
          chk("idle_serOut", serOut, 1'b1);
          chk("idle_done", done, 1'b0);
        end
      end
      prev_ser = serOut;
      prev_busy = busy;
    end
  end

  // Raise start with the given fields and hold it until an idle clkEn edge accepts it.
  task automatic send(input logic [1:0] p, input logic [3:0] n, input logic [14:0] d, output bit ok);
    @(negedge clk);
    port = p; len = n; data = d; start = 1'b1;
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!busy && clkEn && !rst) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!ok) begin
      asserts++;
      fails++;
      $display("FAIL send_timeout: got busy=%0b after 3000 cycles, required an idle accept", busy);
    end else if (n != 0) begin
      exp_q.push_back(model(p, n, d));
    end
    port = 2'($urandom); len = 4'($urandom); data = 15'($urandom);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 3000) begin @(negedge clk); c++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin : main
    bit ok;
    logic [1:0]  rp;
    logic [3:0]  rn;
    logic [14:0] rd;
    #1 rst = 1'b1;
    #1;
    chk("reset_serOut", serOut, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Basic and maximum-length frames
    send(2'b10, 4'd3, 15'h0005, ok);
    send(2'b01, 4'd15, 15'h4001, ok);

    // len=0 request is ignored
    wait_idle();
    send(2'b11, 4'd0, 15'h7fff, ok);
    chk("len0_busy", busy, 1'b0);
    chk("len0_serOut", serOut, 1'b1);
    repeat (12) @(negedge clk);
    chk("len0_still_idle", busy, 1'b0);

    // start re-asserted mid-frame with a new port must not disturb or queue
    send(2'b00, 4'd6, 15'h002d, ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1; port = 2'b11; len = 4'd9; data = 15'h1234;
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    chk("no_queued_frame", busy, 1'b0);

    // Sparse clkEn
    en_div = 4;
    send(2'b10, 4'd1, 15'h0001, ok);
    wait_idle();
    repeat (8) @(negedge clk);
    en_div = 1;

    // Reset during the length field, then a full frame afterwards
    send(2'b11, 4'd6, 15'h0015, ok);
    repeat (3) @(posedge clk);
    #3;
    chk("pre_reset_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_reset_serOut", serOut, 1'b1);
    chk("async_reset_busy", busy, 1'b0);
    chk("async_reset_done", done, 1'b0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    send(2'b01, 4'd5, 15'h0016, ok);

    // Randomized frames, rates and gaps (gap 0 raises start while the previous frame is in flight)
    for (int k = 0; k < 30; k++) begin
      en_div = $urandom_range(1, 3);
      rp = 2'($urandom);
      rn = 4'($urandom_range(0, 15));
      rd = 15'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(rp, rn, rd, ok);
    end

    en_div = 1;
    wait_idle();
    repeat (6) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter: accepts a parallel request of a 2-bit port address, a bit count N and up to 15 data bits, then drives them onto a single serial line. The frame is an active-low start bit, the 2-bit port, the 4-bit length field, then N data bits. It is the sending end of the serial port-demultiplexer link; its output drives the receiver's `serIn` directly, and both ends advance on the same `clkEn` bit-rate tick.

## Interface
- `LEN_W`, default 4: width of the length field; maximum N is 2**LEN_W-1.
- `DATA_W`, default 15 (= 2**LEN_W-1): width of the data payload input.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `clkEn`  in  1: bit-rate enable; all state, counter and `serOut` updates happen only on `clk` edges with `clkEn`=1.
- `start`  in  1: request strobe; sampled only when idle and `clkEn`=1.
- `port`  in  2: destination port address, latched at accept.
- `len`  in  LEN_W: number of data bits N, latched at accept.
- `data`  in  DATA_W: payload; bits `data[N-1:0]` are sent, bits above are ignored; latched at accept.
- `serOut`  out  1: serial line, registered, idles high.
- `busy`  out  1: high from accept until the guard bit ends.
- `done`  out  1: one-`clk` pulse at the end of the last data bit.

## Operation
- States:
  - IDLE: `serOut`=1, `busy`=0.
  - START: 1 bit, `serOut`=0.
  - ADDR: 2 bits.
  - LEN: LEN_W bits.
  - DATA: N bits.
  - GUARD: 1 bit, `serOut`=1.
- Accept condition: IDLE, `clkEn`=1, `start`=1 and `len`!=0.
  - On that edge: latch `port`/`len`/`data`, `serOut`<=0, `busy`<=1, go to START.
- `start` with `len`=0 is ignored: stay IDLE, no `done`, `serOut` stays 1.
- All fields go out MSB first:
  - port: `port[1]`, then `port[0]`.
  - length: `len[LEN_W-1]` down to `len[0]`.
  - data: `data[N-1]` down to `data[0]`.
- Each `clkEn` tick puts the next bit on `serOut` and advances the state:
  - START to ADDR.
  - ADDR to LEN after 2 bits.
  - LEN to DATA after LEN_W bits.
  - DATA to GUARD after N bits.
  - GUARD to IDLE after 1 bit.
- Use a down-counter loaded per field and a shift register loaded at accept. Counter width is LEN_W bits; it must never wrap (N=15 sends exactly 15 bits).
- `done`<=1 on the edge that leaves the last data bit (DATA to GUARD); cleared on the next `clk` edge regardless of `clkEn`.
- `start` while `busy`=1 is ignored and not queued. Input changes after accept do not affect the frame in flight.
- Frames are never back-to-back: at least one high guard bit separates two start bits.

## Timing
- Reset values: `serOut`=1, `busy`=0, `done`=0, state IDLE, counter 0. These take effect immediately on `rst` assertion, including mid-frame; the partial frame is abandoned.
- Latency: the start bit appears on `serOut` after the accepting edge (registered, one `clk` edge).
- A frame occupies 1+2+LEN_W+N `clkEn` ticks of line time, plus 1 guard tick. With LEN_W=4: 7+N+1.
- `busy` rises on the accept edge and falls on the edge where GUARD exits to IDLE. The earliest next accept is that same exit tick's successor, i.e. one tick after `busy` falls.
- `clkEn`=0 for any number of cycles freezes `serOut`, `busy`, state and counters. `done` can only be set on a `clkEn` edge.
- `start` and `clkEn` arriving together on the IDLE exit edge of GUARD: not accepted (not IDLE yet).

## Test plan
- Basic frame: `port`=2'b10, `len`=3, `data`=15'h0005, `start` pulse, `clkEn`=1 every cycle.
  - `serOut` = 0,1,0,0,0,1,1,1,0,1 then 1 (guard).
  - `done` pulses once after the 10th bit; `busy` is high for 11 ticks.
- Maximum length: `port`=2'b01, `len`=15, `data`=15'h4001.
  - 22 bits: 0,0,1,1,1,1,1, then 1, thirteen 0s, 1.
  - No counter wrap; exactly one `done`.
- Ignored requests:
  - `start` with `len`=0: `serOut` stays 1, `busy`=0, no `done`.
  - `start` re-asserted mid-frame with a new `port`: the frame in flight is unchanged and no second frame follows.
- Sparse `clkEn` (1 of every 4 cycles), `len`=1, `data`=1:
  - The bit sequence matches the dense case, each bit held 4 cycles.
  - `done` is exactly 1 `clk` wide.
- Reset mid-frame: assert `rst` during the LEN field.
  - `serOut`=1 and `busy`=0 immediately, before any clock edge.
  - After release, a new request sends a full, correct frame.
- Loopback: connect to the receiver controller and datapath.
  - The receiver selects the sent `port`, outputs N valid bits equal to `data[N-1:0]`, and returns to idle.
